// File: rtl/vfu_request_buffer_pkg.sv
// Lane-wide slot request type and tag geometry.
// Shared by the request buffer, its credit tracker and the bench.
package vfu_request_buffer_pkg;

  localparam int SLOT_REQ_W = 206;
  localparam int TAG_W      = 2;
  localparam int NUM_TAGS   = 4;

  // Tag sits at the LSBs so the buffer can find it without decoding the payload.
  typedef struct packed {
    logic [7:0]       opcode;
    logic [195:0]     operands;
    logic [TAG_W-1:0] tag;
  } slot_request_t;

endpackage

// File: rtl/vfu_tag_credit.sv
// Per-tag outstanding-request counters, credit vector and sticky response error.
// Latency: counts update on the edge after issue/response; credit_ok is registered state.
// Backpressure: credit_ok[t] drops while tag t has MAX_PER_TAG requests unanswered.
module vfu_tag_credit
  import vfu_request_buffer_pkg::*;
#(
  parameter int MAX_PER_TAG = 2,
  parameter int CW          = $clog2(MAX_PER_TAG + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [TAG_W-1:0]       issue_tag,
  input  logic                   resp_valid,
  input  logic [TAG_W-1:0]       resp_tag,
  output logic [NUM_TAGS-1:0]    credit_ok,
  output logic [NUM_TAGS*CW-1:0] inflight,
  output logic                   any_inflight,
  output logic                   resp_error
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PER_TAG);

  logic [CW-1:0]       cnt [NUM_TAGS];
  logic [NUM_TAGS-1:0] inc;
  logic [NUM_TAGS-1:0] dec;

  always_comb begin
    inc          = '0;
    dec          = '0;
    credit_ok    = '0;
    inflight     = '0;
    any_inflight = 1'b0;
    for (int t = 0; t < NUM_TAGS; t++) begin
      inc[t]              = issue_valid && (issue_tag == TAG_W'(t));
      dec[t]              = resp_valid && (resp_tag == TAG_W'(t));
      credit_ok[t]        = cnt[t] < MAX_CNT;
      inflight[t*CW +: CW] = cnt[t];
      any_inflight        = any_inflight | (cnt[t] != '0);
    end
  end

  // A response that coincides with an issue on the same tag nets to zero and is never an error.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NUM_TAGS; t++) cnt[t] <= '0;
      resp_error <= 1'b0;
    end else begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (inc[t] && !dec[t]) begin
          cnt[t] <= cnt[t] + 1'b1;
        end else if (dec[t] && !inc[t]) begin
          if (cnt[t] != '0) cnt[t] <= cnt[t] - 1'b1;
          else              resp_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vfu_request_buffer.sv
// In-order request FIFO between the slot arbiter and the VFU, gated by per-tag credit.
// Latency: one cycle minimum from acceptance to io_out_valid; no pass-through path.
// Backpressure: io_in_ready low when full (no full-bypass); head waits for io_out_ready and tag credit.
module vfu_request_buffer
  import vfu_request_buffer_pkg::*;
#(
  parameter int  DEPTH       = 2,
  parameter int  MAX_PER_TAG = 2,
  parameter int  PAYLOAD_W   = SLOT_REQ_W,
  localparam int CW          = $clog2(MAX_PER_TAG + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic [PAYLOAD_W-1:0]   io_in_bits,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [PAYLOAD_W-1:0]   io_out_bits,
  input  logic                   io_resp_valid,
  input  logic [TAG_W-1:0]       io_resp_tag,
  output logic [NUM_TAGS*CW-1:0] io_inflight,
  output logic                   io_busy,
  output logic                   io_respError
);

  localparam int AW = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW:0]          count;
  logic                 enq;
  logic                 deq;
  logic [TAG_W-1:0]     head_tag;
  logic [NUM_TAGS-1:0]  credit_ok;
  logic                 any_inflight;

  assign head_tag     = mem[rptr][TAG_W-1:0];
  assign io_in_ready  = count != (AW+1)'(DEPTH);
  assign io_out_valid = (count != '0) && credit_ok[head_tag];
  assign io_out_bits  = mem[rptr];
  assign enq          = io_in_valid && io_in_ready;
  assign deq          = io_out_valid && io_out_ready;
  assign io_busy      = (count != '0) || any_inflight;

  // Storage needs no reset: the head is only meaningful while count is non-zero.
  always_ff @(posedge clock) begin
    if (enq) mem[wptr] <= io_in_bits;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (enq) wptr <= wptr + 1'b1;
      if (deq) rptr <= rptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  vfu_tag_credit #(
    .MAX_PER_TAG(MAX_PER_TAG),
    .CW         (CW)
  ) u_credit (
    .clock       (clock),
    .reset       (reset),
    .issue_valid (deq),
    .issue_tag   (head_tag),
    .resp_valid  (io_resp_valid),
    .resp_tag    (io_resp_tag),
    .credit_ok   (credit_ok),
    .inflight    (io_inflight),
    .any_inflight(any_inflight),
    .resp_error  (io_respError)
  );

endmodule

// File: tb/tb_vfu_request_buffer.sv
// Directed bench for vfu_request_buffer with DEPTH=2, MAX_PER_TAG=2.
module tb_vfu_request_buffer;
  import vfu_request_buffer_pkg::*;

  localparam int PW = SLOT_REQ_W;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [PW-1:0] io_in_bits;
  logic          io_out_valid;
  logic          io_out_ready;
  logic [PW-1:0] io_out_bits;
  logic          io_resp_valid;
  logic [1:0]    io_resp_tag;
  logic [7:0]    io_inflight;
  logic          io_busy;
  logic          io_respError;

  int n_checks = 0;
  int n_fail   = 0;

  vfu_request_buffer #(.DEPTH(2), .MAX_PER_TAG(2), .PAYLOAD_W(PW)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_bits   (io_in_bits),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_bits  (io_out_bits),
    .io_resp_valid(io_resp_valid),
    .io_resp_tag  (io_resp_tag),
    .io_inflight  (io_inflight),
    .io_busy      (io_busy),
    .io_respError (io_respError)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [PW-1:0] mkreq(input logic [1:0] tag, input logic [7:0] op);
    slot_request_t r;
    r.opcode   = op;
    r.operands = {op[3:0], {24{op}}};
    r.tag      = tag;
    return r;
  endfunction

  logic [PW-1:0] ra, rb, rc, rd, re, rf, rg;

  initial begin
    reset = 1'b1; io_in_valid = 1'b0; io_in_bits = '0; io_out_ready = 1'b0;
    io_resp_valid = 1'b0; io_resp_tag = '0;
    tick; tick;
    reset = 1'b0;

    // Reset then idle
    check("rst_err", io_respError, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("idle_in_ready", io_in_ready, 1'b1);
      check("idle_out_valid", io_out_valid, 1'b0);
      check("idle_inflight", io_inflight, 8'h00);
      check("idle_busy", io_busy, 1'b0);
      tick;
    end

    // Back-to-back stream of tags 0..3
    io_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        io_in_valid = 1'b1;
        io_in_bits  = mkreq(2'(i), 8'(8'h10 + i));
      end else begin
        io_in_valid = 1'b0;
      end
      if (i == 0) check("stream_no_passthru", io_out_valid, 1'b0);
      else begin
        check("stream_valid", io_out_valid, 1'b1);
        check("stream_bits", io_out_bits, mkreq(2'(i - 1), 8'(8'h10 + i - 1)));
      end
      check("stream_in_ready", io_in_ready, 1'b1);
      tick;
    end
    check("stream_drained", io_out_valid, 1'b0);
    check("stream_inflight", io_inflight, 8'h55);
    check("stream_busy", io_busy, 1'b1);
    for (int t = 0; t < 4; t++) begin
      io_resp_valid = 1'b1; io_resp_tag = 2'(t);
      tick;
    end
    io_resp_valid = 1'b0;
    check("clear_inflight", io_inflight, 8'h00);
    check("clear_busy", io_busy, 1'b0);
    check("clear_err", io_respError, 1'b0);

    // Credit stall on tag 0 with head-of-line blocking
    ra = mkreq(2'd0, 8'hA0); rb = mkreq(2'd0, 8'hB0);
    rc = mkreq(2'd0, 8'hC0); rd = mkreq(2'd1, 8'hD1);
    io_in_valid = 1'b1; io_in_bits = ra;
    tick;
    check("hol_a_valid", io_out_valid, 1'b1);
    check("hol_a_bits", io_out_bits, ra);
    io_in_bits = rb;
    tick;
    check("hol_b_valid", io_out_valid, 1'b1);
    check("hol_b_bits", io_out_bits, rb);
    io_in_bits = rc;
    tick;
    check("hol_c_stall", io_out_valid, 1'b0);
    check("hol_d_accept", io_in_ready, 1'b1);
    io_in_bits = rd;
    tick;
    io_in_valid = 1'b0;
    check("hol_still_stall", io_out_valid, 1'b0);
    check("hol_head_c", io_out_bits, rc);
    check("hol_full", io_in_ready, 1'b0);
    check("hol_inflight", io_inflight, 8'h02);
    tick;
    check("hol_stall2", io_out_valid, 1'b0);
    io_resp_valid = 1'b1; io_resp_tag = 2'd0;
    tick;
    io_resp_valid = 1'b0;
    check("hol_release_valid", io_out_valid, 1'b1);
    check("hol_release_bits", io_out_bits, rc);
    check("hol_release_inflight", io_inflight, 8'h01);
    tick;
    check("hol_d_valid", io_out_valid, 1'b1);
    check("hol_d_bits", io_out_bits, rd);
    tick;
    check("hol_empty", io_out_valid, 1'b0);
    check("hol_end_inflight", io_inflight, 8'h06);
    io_resp_valid = 1'b1; io_resp_tag = 2'd0; tick;
    io_resp_tag = 2'd0; tick;
    io_resp_tag = 2'd1; tick;
    io_resp_valid = 1'b0;
    check("hol_cleared", io_inflight, 8'h00);

    // Full FIFO: no full-bypass on dequeue
    re = mkreq(2'd2, 8'hE2); rf = mkreq(2'd3, 8'hF3); rg = mkreq(2'd1, 8'h61);
    io_out_ready = 1'b0;
    io_in_valid = 1'b1; io_in_bits = re;
    check("full_rdy0", io_in_ready, 1'b1);
    tick;
    check("full_rdy1", io_in_ready, 1'b1);
    io_in_bits = rf;
    tick;
    check("full_rdy_drop", io_in_ready, 1'b0);
    io_in_bits = rg;
    tick;
    check("full_rdy_hold", io_in_ready, 1'b0);
    io_out_ready = 1'b1;
    check("full_deq_cycle_rdy", io_in_ready, 1'b0);
    check("full_deq_valid", io_out_valid, 1'b1);
    check("full_deq_bits", io_out_bits, re);
    tick;
    check("full_rdy_back", io_in_ready, 1'b1);
    check("full_f_bits", io_out_bits, rf);
    tick;
    io_in_valid = 1'b0;
    check("full_g_valid", io_out_valid, 1'b1);
    check("full_g_bits", io_out_bits, rg);
    tick;
    io_out_ready = 1'b0;
    check("full_empty", io_out_valid, 1'b0);
    check("full_inflight", io_inflight, 8'h54);

    // Same-cycle issue and response on tag 2 (count 1)
    io_out_ready = 1'b1;
    io_in_valid = 1'b1; io_in_bits = mkreq(2'd2, 8'h22);
    tick;
    io_in_valid = 1'b0;
    check("same2_valid", io_out_valid, 1'b1);
    io_resp_valid = 1'b1; io_resp_tag = 2'd2;
    tick;
    io_resp_valid = 1'b0;
    check("same2_inflight", io_inflight, 8'h54);

    // Same-cycle issue and response on tag 0 (count 0): not an error
    io_in_valid = 1'b1; io_in_bits = mkreq(2'd0, 8'h30);
    tick;
    io_in_valid = 1'b0;
    io_resp_valid = 1'b1; io_resp_tag = 2'd0;
    tick;
    io_resp_valid = 1'b0;
    check("same0_inflight", io_inflight, 8'h54);
    check("same0_no_err", io_respError, 1'b0);

    // Underflow on tag 3 sets the sticky error
    io_resp_valid = 1'b1; io_resp_tag = 2'd3;
    tick;
    check("t3_dec", io_inflight, 8'h14);
    check("t3_dec_no_err", io_respError, 1'b0);
    tick;
    io_resp_valid = 1'b0;
    check("t3_err_set", io_respError, 1'b1);
    check("t3_count_held", io_inflight, 8'h14);
    tick; tick; tick;
    check("t3_err_sticky", io_respError, 1'b1);

    // Reset mid-operation with queued entries and inflight {0,2,1,0}
    io_in_valid = 1'b1; io_in_bits = mkreq(2'd2, 8'h42);
    tick;
    io_in_valid = 1'b0;
    tick;
    io_out_ready = 1'b0;
    check("pre_rst_inflight", io_inflight, 8'h24);
    io_in_valid = 1'b1; io_in_bits = mkreq(2'd1, 8'h51);
    tick;
    io_in_bits = mkreq(2'd0, 8'h50);
    tick;
    io_in_valid = 1'b0;
    check("pre_rst_full", io_in_ready, 1'b0);
    check("pre_rst_busy", io_busy, 1'b1);
    reset = 1'b1; io_resp_valid = 1'b1; io_resp_tag = 2'd2;
    tick;
    reset = 1'b0; io_resp_valid = 1'b0;
    check("rst_in_ready", io_in_ready, 1'b1);
    check("rst_out_valid", io_out_valid, 1'b0);
    check("rst_inflight", io_inflight, 8'h00);
    check("rst_busy", io_busy, 1'b0);
    check("rst_err_clear", io_respError, 1'b0);
    tick;
    check("post_rst_valid", io_out_valid, 1'b0);
    check("post_rst_err", io_respError, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
